// File: rtl/pc_fetch_if.sv
// Fetch-unit bus: redirect/stall/halt controls in, PC and status out.
// The fetch unit takes the slave side; the datapath/control drives the master side.
interface pc_fetch_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] imem_addr;
    logic        fetch_valid;
    logic        halted;
    logic        fault;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_target,
               jump_reg, jr_target, halt_req,
        input  pc, pc_plus4, imem_addr, fetch_valid, halted, fault
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_target,
               jump_reg, jr_target, halt_req,
        output pc, pc_plus4, imem_addr, fetch_valid, halted, fault
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC selection for a single-cycle MIPS32 datapath.
// FSM BOOT -> RUN -> HALT; HALT is left only through rst.
// Optional build macro BRANCH_DELAY_SLOT_EN: taken redirects go through a
// pending register so the instruction after the redirect (delay slot) runs first.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 64
) (
    input  logic      clk,
    input  logic      rst,
    pc_fetch_if.slave bus
);
    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] redir_target;
    logic [31:0] next_pc;
    logic        redirect;
    logic        misaligned;
    logic        misaligned_eff;
    logic        out_of_bounds;
    logic        sampled;
    logic        halt_now;
    logic        fault_now;
    logic        pc_load;
    logic        fault_q;

    assign pc_plus4 = pc_q + 32'd4;
    // Inputs only count in RUN with no stall; otherwise the caller re-presents them.
    assign sampled  = (state == RUN) && !bus.stall;

    // Redirect target by priority: jump_reg > jump > branch_taken > sequential.
    always_comb begin
        redirect     = 1'b1;
        misaligned   = 1'b0;
        redir_target = pc_plus4;
        if (bus.jump_reg) begin
            redir_target = bus.jr_target;
            misaligned   = |bus.jr_target[1:0];
        end else if (bus.jump) begin
            redir_target = {pc_plus4[31:28], bus.jump_target, 2'b00};
        end else if (bus.branch_taken) begin
            redir_target = pc_plus4 + (bus.branch_offset << 2);
        end else begin
            redirect = 1'b0;
        end
    end

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend_vld;
    logic [31:0] pend_target;

    // A latched target wins over anything new; otherwise fetch the delay slot.
    always_comb begin
        next_pc        = pend_vld ? pend_target : pc_plus4;
        misaligned_eff = misaligned && redirect && !pend_vld;
    end

    // Pending target: captured on a taken redirect, consumed on the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld    <= 1'b0;
            pend_target <= 32'd0;
        end else if (halt_now || fault_now) begin
            pend_vld    <= 1'b0;
        end else if (pc_load) begin
            if (pend_vld) begin
                pend_vld    <= 1'b0;
            end else if (redirect) begin
                pend_vld    <= 1'b1;
                pend_target <= redir_target;
            end
        end
    end
`else
    // Redirect takes effect directly on the next PC.
    always_comb begin
        next_pc        = redirect ? redir_target : pc_plus4;
        misaligned_eff = misaligned;
    end
`endif

    assign out_of_bounds = {2'b00, next_pc[31:2]} >= DEPTH_W;
    assign halt_now      = sampled && bus.halt_req;
    assign fault_now     = sampled && !bus.halt_req && (misaligned_eff || out_of_bounds);
    assign pc_load       = sampled && !bus.halt_req && !fault_now;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    // FSM next state: one BOOT cycle, then run until halt or fault.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (halt_now || fault_now) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.fetch_valid = (state == RUN);
        bus.halted      = (state == HALT);
    end

    // PC and sticky fault; PC never moves on halt or fault cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            if (pc_load)   pc_q    <= next_pc;
            if (fault_now) fault_q <= 1'b1;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.imem_addr = {2'b00, pc_q[31:2]};
    assign bus.fault     = fault_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit (default build): directed vectors, a per-cycle
// reference model compared on every falling edge, and literal spot checks.
module tb_pc_fetch_unit;
    localparam int unsigned DEPTH = 64;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    pc_fetch_if bus ();

    pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: plain PC plus "booting"/"halted"/"fault" facts.
    logic [31:0] m_pc;
    logic        m_boot;
    logic        m_halt;
    logic        m_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Next PC from the architectural rules; bit 32 flags a fault.
    function automatic logic [32:0] model_next(input logic [31:0] p);
        logic [31:0] seq;
        logic [31:0] t;
        logic        bad;
        seq = p + 32'd4;
        bad = 1'b0;
        if (bus.jump_reg) begin
            t   = bus.jr_target;
            bad = (bus.jr_target % 4) != 0;
        end else if (bus.jump) begin
            t = (seq & 32'hF000_0000) | ({6'd0, bus.jump_target} * 32'd4);
        end else if (bus.branch_taken) begin
            t = seq + bus.branch_offset * 32'd4;
        end else begin
            t = seq;
        end
        if (t / 4 >= DEPTH) bad = 1'b1;
        return {bad, t};
    endfunction

    // Model update on each rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc    <= 32'h0;
            m_boot  <= 1'b1;
            m_halt  <= 1'b0;
            m_fault <= 1'b0;
        end else if (m_boot) begin
            m_boot <= 1'b0;
        end else if (!m_halt && !bus.stall) begin
            if (bus.halt_req) begin
                m_halt <= 1'b1;
            end else if (model_next(m_pc) >> 32) begin
                m_fault <= 1'b1;
                m_halt  <= 1'b1;
            end else begin
                m_pc <= model_next(m_pc) & 33'h0_FFFF_FFFF;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        chk("cyc_pc",          bus.pc,                    m_pc);
        chk("cyc_pc_plus4",    bus.pc_plus4,              m_pc + 32'd4);
        chk("cyc_imem_addr",   bus.imem_addr,             m_pc / 4);
        chk("cyc_fetch_valid", {31'd0, bus.fetch_valid},  {31'd0, !m_boot && !m_halt});
        chk("cyc_halted",      {31'd0, bus.halted},       {31'd0, m_halt});
        chk("cyc_fault",       {31'd0, bus.fault},        {31'd0, m_fault});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 32'd0;
        bus.jump          = 1'b0;
        bus.jump_target   = 26'd0;
        bus.jump_reg      = 1'b0;
        bus.jr_target     = 32'd0;
        bus.halt_req      = 1'b0;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        #1;
        chk("rst_pc",    bus.pc,                   32'h0);
        chk("rst_fault", {31'd0, bus.fault},       32'd0);
        chk("rst_fv",    {31'd0, bus.fetch_valid}, 32'd0);
        chk("rst_halt",  {31'd0, bus.halted},      32'd0);
        rst = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b0;
        clear_in();
        #1;
        rst_pulse();

        // Boot cycle then sequential fetch.
        chk("boot_fv", {31'd0, bus.fetch_valid}, 32'd0);
        tick();
        chk("run_fv",  {31'd0, bus.fetch_valid}, 32'd1);
        chk("seq_pc0", bus.pc, 32'h0);
        tick();
        chk("seq_pc4", bus.pc, 32'h4);
        chk("seq_ia1", bus.imem_addr, 32'd1);
        tick();
        chk("seq_pc8", bus.pc, 32'h8);
        chk("seq_ia2", bus.imem_addr, 32'd2);

        // Backward and forward branches from 0x08.
        bus.branch_taken = 1'b1; bus.branch_offset = 32'hFFFF_FFFE;
        tick();
        chk("br_back", bus.pc, 32'h4);
        clear_in();
        tick();
        chk("br_back_seq", bus.pc, 32'h8);
        bus.branch_taken = 1'b1; bus.branch_offset = 32'd3;
        tick();
        chk("br_fwd", bus.pc, 32'h18);
        bus.branch_offset = 32'hFFFF_FFFD;
        tick();
        chk("br_to_10", bus.pc, 32'h10);

        // Jump beats branch.
        bus.jump = 1'b1; bus.jump_target = 26'h000005; bus.branch_offset = 32'd7;
        tick();
        chk("jmp_wins", bus.pc, 32'h14);
        clear_in();

        // Stall holds PC with jr asserted; jr lands once stall drops.
        bus.stall = 1'b1; bus.jump_reg = 1'b1; bus.jr_target = 32'h20;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", bus.pc, 32'h14);
        end
        bus.stall = 1'b0;
        tick();
        chk("jr_after_stall", bus.pc, 32'h20);

        // Misaligned jr: fault, halt, PC unchanged.
        bus.jr_target = 32'h22;
        tick();
        chk("mis_fault", {31'd0, bus.fault},  32'd1);
        chk("mis_halt",  {31'd0, bus.halted}, 32'd1);
        chk("mis_pc",    bus.pc, 32'h20);
        clear_in();
        tick();
        chk("halt_term", bus.pc, 32'h20);

        // Sequential step past the last word faults.
        #2;
        rst_pulse();
        tick();
        bus.jump_reg = 1'b1; bus.jr_target = 32'hFC;
        tick();
        chk("jr_fc", bus.pc, 32'hFC);
        clear_in();
        tick();
        chk("oob_fault", {31'd0, bus.fault}, 32'd1);
        chk("oob_pc",    bus.pc, 32'hFC);

        // halt_req ignored under stall, then wins over a branch.
        #2;
        rst_pulse();
        tick(); tick(); tick();
        chk("pre_halt_pc", bus.pc, 32'h8);
        bus.stall = 1'b1; bus.halt_req = 1'b1; bus.branch_taken = 1'b1; bus.branch_offset = 32'd3;
        tick();
        chk("stall_no_halt", {31'd0, bus.halted}, 32'd0);
        bus.stall = 1'b0;
        tick();
        chk("halt_in", {31'd0, bus.halted}, 32'd1);
        chk("halt_pc", bus.pc, 32'h8);
        chk("halt_nf", {31'd0, bus.fault}, 32'd0);
        clear_in();
        bus.jump = 1'b1; bus.jump_target = 26'd1;
        tick(); tick();
        chk("halt_hold", bus.pc, 32'h8);
        clear_in();

        // Asynchronous reset mid-cycle.
        #3;
        rst_pulse();
        tick(); tick();
        chk("post_rst_pc", bus.pc, 32'h4);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
